proc_rst_seq: RTL and testbench
===============================

// Module: proc_rst_seq
// PURPOSE
//   Parametrised reset/error sequencer for the multi-core processor hierarchy.
//   Holds N_CORES cores in reset after global rst, then releases them one at a time.
//   Counts run cycles and latches the first core error, recording core index and cycle.
//   Halts all cores (re-asserts their resets) until software/bench issues clr_err.
// PARAMETERS
//   N_CORES   2   number of cores sequenced (>=1)
//   RST_HOLD  8   cycles core 0 stays in reset after rst deasserts (>=1)
//   STAGGER   2   cycles between successive core releases (>=1)
//   CYC_W     32  width of cycle counters
//   ID_W      derived: max(1,$clog2(N_CORES)); not overridable
// PORTS
//   clk        in   1        system clock, all state on rising edge
//   rst        in   1        asynchronous, active-high reset
//   err        in   N_CORES  per-core error flag, level
//   clr_err    in   1        sync pulse: leave HALT and restart sequence
//   core_rst   out  N_CORES  per-core reset, active-high
//   halt       out  1        1 while in HALT
//   err_valid  out  1        first-error record valid
//   err_core   out  ID_W     index of erroring core
//   err_cycle  out  CYC_W    cycle_cnt value when error latched
//   cycle_cnt  out  CYC_W    run cycles since core 0 release, saturating
//   state      out  2        HOLD=0 RELEASE=1 RUN=2 HALT=3
// BEHAVIOUR
//   - rst=1 (async, no clock needed): state=HOLD, core_rst=all 1s, cnt=0,
//     cycle_cnt=0, err_valid=0, err_core=0, err_cycle=0, halt=0.
//   - HOLD: cnt++ per edge. At edge where cnt==RST_HOLD-1:
//     core_rst[0]<=0, cnt<=0. Next state is RELEASE if N_CORES>1, else RUN.
//   - RELEASE: cnt++. At cnt==STAGGER-1, clear the next core_rst bit and set cnt<=0.
//     When the last core is cleared, go to RUN.
//     Core k falls at edge RST_HOLD+k*STAGGER after rst release.
//   - RUN: steady state; cores stay released.
//   - cycle_cnt: +1 on every edge where core_rst[0] was already 0 and state!=HALT.
//     Saturates at all-ones; it does not wrap.
//   - Error detect, in RELEASE/RUN only: qualified err = err & ~core_rst.
//     Errors from cores still in reset are ignored.
//     Any qualified bit set at an edge causes all of the following at that edge:
//       state<=HALT, halt<=1, err_valid<=1, core_rst<=all 1s.
//       err_core<=lowest set index.
//       err_cycle<=cycle_cnt pre-increment; cycle_cnt does not increment that edge.
//   - HALT: err ignored; cycle_cnt and error record frozen.
//     clr_err=1 at an edge: state<=HOLD, cnt<=0, cycle_cnt<=0, err_valid<=0, halt<=0.
//     err_core and err_cycle keep their values. The sequence restarts with the same
//     timing, counted from that edge.
//   - clr_err is ignored outside HALT. An error coincident with clr_err in HALT is
//     ignored (clr wins).
//   - Error on the same edge as a scheduled release: HALT wins; all resets asserted.
//   - rst mid-sequence or in HALT: immediate return to reset values.
// TESTING (N_CORES=2, RST_HOLD=4, STAGGER=3, CYC_W=32 unless noted)
//   1. rst low before edge 1 -> core_rst=10b after edge 4, 00b after edge 7.
//      state=RUN and cycle_cnt=3 after edge 7.
//   2. err[1]=1 before edge 6 (core 1 still in reset) -> ignored, no halt.
//      err[0]=1 before edge 10 -> after edge 10: halt=1, err_core=0, err_cycle=5,
//      core_rst=11b.
//   3. err=11b both qualified in RUN -> err_core=0. cycle_cnt frozen while HALT.
//   4. clr_err pulse in HALT at edge E -> HOLD, err_valid=0, cycle_cnt=0.
//      core_rst[0] falls at edge E+4, core_rst[1] at edge E+7. err_core/err_cycle retained.
//   5. rst pulsed between clock edges during RELEASE -> core_rst=11b and state=HOLD
//      immediately, with no clock edge.
//   6. CYC_W=4, run 30 cycles -> cycle_cnt holds at 15. Error then gives err_cycle=15.

Source files
------------

// File: rtl/proc_rst_seq.sv
// proc_rst_seq: staggered core reset release with first-error capture and halt
module proc_rst_seq #(
  parameter int N_CORES = 2,
  parameter int RST_HOLD = 8,
  parameter int STAGGER = 2,
  parameter int CYC_W = 32,
  localparam int ID_W = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_CORES-1:0] err,
  input  logic               clr_err,
  output logic [N_CORES-1:0] core_rst,
  output logic               halt,
  output logic               err_valid,
  output logic [ID_W-1:0]    err_core,
  output logic [CYC_W-1:0]   err_cycle,
  output logic [CYC_W-1:0]   cycle_cnt,
  output logic [1:0]         state
);
  typedef enum logic [1:0] {HOLD, RELEASE, RUN, HALT} st_t;
  st_t st;
  logic [31:0] cnt;
  logic [ID_W-1:0] idx;
  logic [N_CORES-1:0] qerr;
  logic [ID_W-1:0] low;
  assign state = st;
  // errors only count from cores already out of reset; pick the lowest index
  always_comb begin
    qerr = err & ~core_rst;
    low = '0;
    for (int i = N_CORES - 1; i >= 0; i--) if (qerr[i]) low = ID_W'(i);
  end
  // sequencer: hold, staggered release, run, halt on first error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= HOLD;
      core_rst <= '1;
      cnt <= '0;
      idx <= ID_W'(1);
      cycle_cnt <= '0;
      err_valid <= 1'b0;
      err_core <= '0;
      err_cycle <= '0;
      halt <= 1'b0;
    end else begin
      case (st)
        HOLD: begin
          if (cnt == 32'(RST_HOLD - 1)) begin
            core_rst[0] <= 1'b0;
            cnt <= '0;
            idx <= ID_W'(1);
            st <= (N_CORES > 1) ? RELEASE : RUN;
          end else cnt <= cnt + 1;
        end
        RELEASE, RUN: begin
          if (|qerr) begin
            st <= HALT;
            halt <= 1'b1;
            err_valid <= 1'b1;
            core_rst <= '1;
            err_core <= low;
            err_cycle <= cycle_cnt;
          end else begin
            if (~&cycle_cnt) cycle_cnt <= cycle_cnt + 1'b1;
            if (st == RELEASE) begin
              if (cnt == 32'(STAGGER - 1)) begin
                core_rst[idx] <= 1'b0;
                cnt <= '0;
                idx <= idx + 1'b1;
                if (idx == ID_W'(N_CORES - 1)) st <= RUN;
              end else cnt <= cnt + 1;
            end
          end
        end
        HALT: begin
          if (clr_err) begin
            st <= HOLD;
            cnt <= '0;
            cycle_cnt <= '0;
            err_valid <= 1'b0;
            halt <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_proc_rst_seq.sv
// tb_proc_rst_seq: directed and random checks of proc_rst_seq against a timeline model
module tb_proc_rst_seq;
  localparam int RH = 4, ST = 3;
  logic clk = 0, rst = 1, clr_err = 0;
  logic [1:0] err = 0;
  logic [1:0] core_rst, state;
  logic halt, err_valid;
  logic [0:0] err_core;
  logic [31:0] err_cycle, cycle_cnt;
  logic rst4 = 1, clr4 = 0;
  logic [1:0] err4 = 0;
  logic [1:0] core_rst4, state4;
  logic halt4, err_valid4;
  logic [0:0] err_core4;
  logic [3:0] err_cycle4, cycle_cnt4;
  int total = 0, bad = 0;
  bit chk = 0, done4 = 0;
  always #5 clk = ~clk;
  proc_rst_seq #(.N_CORES(2), .RST_HOLD(RH), .STAGGER(ST), .CYC_W(32)) dut (
    .clk(clk), .rst(rst), .err(err), .clr_err(clr_err), .core_rst(core_rst), .halt(halt),
    .err_valid(err_valid), .err_core(err_core), .err_cycle(err_cycle), .cycle_cnt(cycle_cnt),
    .state(state));
  proc_rst_seq #(.N_CORES(2), .RST_HOLD(RH), .STAGGER(ST), .CYC_W(4)) dut4 (
    .clk(clk), .rst(rst4), .err(err4), .clr_err(clr4), .core_rst(core_rst4), .halt(halt4),
    .err_valid(err_valid4), .err_core(err_core4), .err_cycle(err_cycle4), .cycle_cnt(cycle_cnt4),
    .state(state4));
  task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", n, a, e);
    end
  endtask
  // model: t = edges since the sequence (re)started; core k is out of reset once t >= RH+k*ST
  int t;
  logic [31:0] mcyc, mecyc;
  logic mhalt, mev, mcore;
  logic [1:0] q, cr, mcr;
  logic [1:0] ms;
  function automatic logic [1:0] crs_of(input int tt);
    logic [1:0] r;
    for (int k = 0; k < 2; k++) r[k] = tt < RH + k * ST;
    return r;
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t = 0; mcyc = 0; mhalt = 0; mev = 0; mcore = 0; mecyc = 0;
    end else if (mhalt) begin
      if (clr_err) begin
        mhalt = 0; t = 0; mcyc = 0; mev = 0;
      end
    end else begin
      cr = crs_of(t);
      q = err & ~cr;
      if (q != 0) begin
        mhalt = 1; mev = 1; mecyc = mcyc;
        mcore = q[0] ? 1'b0 : 1'b1;
      end else begin
        if (!cr[0] && mcyc != 32'hffff_ffff) mcyc = mcyc + 1;
        t = t + 1;
      end
    end
  end
  always @(negedge clk) begin
    if (chk) begin
      mcr = mhalt ? 2'b11 : crs_of(t);
      ms = mhalt ? 2'd3 : (t < RH) ? 2'd0 : (t < RH + ST) ? 2'd1 : 2'd2;
      check("m_core_rst", core_rst, mcr);
      check("m_state", state, ms);
      check("m_halt", halt, mhalt);
      check("m_err_valid", err_valid, mev);
      check("m_err_core", err_core, mcore);
      check("m_err_cycle", err_cycle, mecyc);
      check("m_cycle_cnt", cycle_cnt, mcyc);
    end
  end
  task automatic cyc(input logic [1:0] e, input logic c);
    err = e;
    clr_err = c;
    @(posedge clk);
    @(negedge clk);
    err = 0;
    clr_err = 0;
  endtask
  initial begin
    @(posedge clk);
    @(negedge clk);
    chk = 1;
    check("rst_core_rst", core_rst, 2'b11);
    check("rst_state", state, 0);
    check("rst_cycle", cycle_cnt, 0);
    check("rst_err_valid", err_valid, 0);
    check("rst_err_cycle", err_cycle, 0);
    rst = 0;
    repeat (4) cyc(0, 0);
    check("t1_rel0", core_rst, 2'b10);
    check("t1_state_rel", state, 1);
    cyc(0, 0);
    cyc(2'b10, 0);
    check("t2_ignored", halt, 0);
    cyc(0, 0);
    check("t1_rel1", core_rst, 2'b00);
    check("t1_run", state, 2);
    check("t1_cycle", cycle_cnt, 3);
    repeat (2) cyc(0, 0);
    cyc(2'b01, 0);
    check("t2_halt", halt, 1);
    check("t2_err_core", err_core, 0);
    check("t2_err_cycle", err_cycle, 5);
    check("t2_core_rst", core_rst, 2'b11);
    repeat (3) cyc(2'b11, 0);
    check("t3_frozen", cycle_cnt, 5);
    check("t3_state", state, 3);
    cyc(0, 1);
    check("t4_state", state, 0);
    check("t4_valid", err_valid, 0);
    check("t4_cycle", cycle_cnt, 0);
    check("t4_keep_cycle", err_cycle, 5);
    repeat (3) cyc(0, 0);
    check("t4_hold3", core_rst, 2'b11);
    cyc(0, 0);
    check("t4_rel0", core_rst, 2'b10);
    repeat (2) cyc(0, 0);
    check("t4_still1", core_rst, 2'b10);
    cyc(0, 0);
    check("t4_rel1", core_rst, 2'b00);
    cyc(2'b10, 0);
    check("t3_core1", err_core, 1);
    check("t3_cycle1", err_cycle, 3);
    cyc(0, 1);
    repeat (7) cyc(0, 0);
    cyc(2'b11, 0);
    check("t3_lowest", err_core, 0);
    cyc(0, 1);
    repeat (5) cyc(0, 0);
    check("t5_release", state, 1);
    #1 rst = 1;
    #1;
    check("t5_async_rst", core_rst, 2'b11);
    check("t5_async_state", state, 0);
    #1 rst = 0;
    for (int i = 0; i < 600; i++) begin
      err = {$urandom_range(19) == 0, $urandom_range(19) == 0};
      clr_err = $urandom_range(3) == 0;
      if ($urandom_range(149) == 0) begin
        #1 rst = 1;
        #1 rst = 0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    wait (done4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    @(posedge clk);
    @(negedge clk);
    check("s_rst_cycle", cycle_cnt4, 0);
    rst4 = 0;
    repeat (18) @(posedge clk);
    @(negedge clk);
    check("s_cycle14", cycle_cnt4, 14);
    @(posedge clk);
    @(negedge clk);
    check("s_cycle15", cycle_cnt4, 15);
    repeat (11) @(posedge clk);
    @(negedge clk);
    check("s_saturated", cycle_cnt4, 15);
    check("s_no_halt", halt4, 0);
    err4 = 2'b01;
    @(posedge clk);
    @(negedge clk);
    err4 = 0;
    check("s_halt", halt4, 1);
    check("s_err_cycle", err_cycle4, 15);
    check("s_frozen", cycle_cnt4, 15);
    done4 = 1;
  end
endmodule
